uart_tx_arb: RTL and testbench

- Round-robin arbiter and packet scheduler that shares one UART transmitter between N byte-stream requesters.
- Each requester presents bytes with a last-of-packet flag. A grant is held for a whole packet, so packets never interleave on the serial line.
- Sits between the firmware/debug/status byte producers and the existing uart_tx valid/ready byte interface.

---
 rtl/uart_arb_pkg.sv | 12 +
 rtl/uart_tx_arb_rr_pick.sv | 34 +++
 rtl/uart_tx_arb.sv | 126 ++++++++++++
 tb/tb_uart_tx_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        TAG  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    localparam logic [7:0] TAG_BASE = 8'hA0;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin first-set finder: returns the first set request
// at or above ptr, wrapping modulo N.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    logic [2*N-1:0] rot;
    int             sum;

    // Rotating a doubled copy puts the candidate at ptr in bit 0.
    always_comb begin
        rot   = {req, req} >> ptr;
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = int'(ptr) + k;
                if (sum >= N) begin
                    sum = sum - N;
                end
                idx = ID_W'(sum);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter sharing one uart_tx byte interface between N_REQ
// requesters. Define UART_ARB_TAG_EN to prefix each packet with 8'hA0|grant_id.
module uart_tx_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic [ID_W-1:0]    grant_id
);

    import uart_arb_pkg::*;

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;

    logic            can_load;
    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic            sel_valid, sel_last;
    logic [7:0]      sel_data;
    logic            accept;
    logic [ID_W-1:0] next_ptr;

    rr_pick #(.N(N_REQ), .ID_W(ID_W)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // The output register may refill in the same cycle its byte leaves.
    assign can_load = !tx_valid_q || tx_ready;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                sel_valid    = req_valid[i];
                sel_last     = req_last[i];
                sel_data     = req_data[8*i +: 8];
                req_ready[i] = (state_q == XFER) && can_load;
            end
        end
    end

    assign accept   = sel_valid && (state_q == XFER) && can_load;
    assign next_ptr = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q && !tx_ready;
        case (state_q)
            ARB: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
`ifdef UART_ARB_TAG_EN
                    state_d    = TAG;
`else
                    state_d    = XFER;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG: begin
                if (can_load) begin
                    tx_data_d  = TAG_BASE | 8'(grant_id_q);
                    tx_valid_d = 1'b1;
                    state_d    = XFER;
                end
            end
`endif
            XFER: begin
                // A silent granted requester keeps the grant; only its last byte frees it.
                if (accept) begin
                    tx_data_d  = sel_data;
                    tx_valid_d = 1'b1;
                    if (sel_last) begin
                        rr_ptr_d = next_ptr;
                        state_d  = ARB;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != ARB) || tx_valid_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with N_REQ=4; tag bytes are expected when
// UART_ARB_TAG_EN is defined.
module tb_uart_tx_arb;

`ifdef UART_ARB_TAG_EN
    localparam bit TAG_ON = 1'b1;
`else
    localparam bit TAG_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [2:0]  grant_id;

    uart_tx_arb #(.N_REQ(4), .ID_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sources, line capture and scoreboard
    logic [8:0] src_q [4][$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit   [3:0] stall;
    bit         ready_hold;
    int         gap;
    int         multi_acc;
    int         total;
    int         bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [8:0] h;
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0 && !stall[i]) begin
                h = src_q[i][0];
                req_valid[i]        = 1'b1;
                req_last[i]         = h[8];
                req_data[8*i +: 8]  = h[7:0];
            end else begin
                req_valid[i]        = 1'b0;
                req_last[i]         = 1'b0;
                req_data[8*i +: 8]  = 8'h00;
            end
        end
    endtask

    // One clock: sample handshakes at negedge, apply their effect after posedge.
    task automatic cycle();
        logic [3:0] acc;
        logic       tx_x;
        @(negedge clk);
        acc  = req_valid & req_ready;
        tx_x = tx_valid && tx_ready;
        if (tx_x) got_q.push_back(tx_data);
        if ($countones(acc) > 1) multi_acc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) void'(src_q[i].pop_front());
        end
        if (tx_x) gap = 2;
        if (ready_hold) begin
            tx_ready = 1'b0;
        end else if (gap > 0) begin
            tx_ready = 1'b0;
            gap--;
        end else begin
            tx_ready = 1'b1;
        end
        drive();
    endtask

    function automatic bit srcs_empty();
        return (src_q[0].size() == 0) && (src_q[1].size() == 0) &&
               (src_q[2].size() == 0) && (src_q[3].size() == 0);
    endfunction

    task automatic run_idle(input string tag, input int max);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max && !done; c++) begin
            cycle();
            if (srcs_empty() && !busy) done = 1'b1;
        end
        chk({tag, "_idle"}, done, 1);
    endtask

    task automatic wait_src(input string tag, input int i, input int n, input int max);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max && !done; c++) begin
            cycle();
            if (src_q[i].size() == n) done = 1'b1;
        end
        chk({tag, "_wait"}, done, 1);
    endtask

    task automatic exp_tag(input int i);
        if (TAG_ON) exp_q.push_back(8'hA0 | 8'(i));
    endtask

    task automatic chk_sb(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_byte%0d", tag, k), got_q[k], exp_q[k]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    int  unstable;
    int  gap_valid;

    initial begin
        total = 0; bad = 0; multi_acc = 0; gap = 0;
        stall = '0; ready_hold = 1'b0;
        rst = 1'b1; tx_ready = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0;

        // reset state
        #3;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_req_ready", req_ready, 4'h0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        cycle();
        rst = 1'b0;

        // single request on requester 1
        src_q[1].push_back(9'h055);
        src_q[1].push_back(9'h166);
        drive();
        cycle();
        chk("single_grant", grant_id, 1);
        chk("single_busy", busy, 1);
        exp_tag(1); exp_q.push_back(8'h55); exp_q.push_back(8'h66);
        run_idle("single", 200);
        chk_sb("single");
        chk("single_busy_end", busy, 0);
        chk("single_grant_hold", grant_id, 1);

        // contention between requesters 0 and 2 from reset
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            src_q[0].push_back({(k == 3), 8'(8'h00 + k)});
            src_q[2].push_back({(k == 3), 8'(8'h20 + k)});
        end
        drive();
        exp_tag(0); exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        exp_tag(2); exp_q.push_back(8'h21); exp_q.push_back(8'h22); exp_q.push_back(8'h23);
        run_idle("contend", 300);
        chk_sb("contend");
        chk("contend_grant", grant_id, 2);

        // fairness with single-byte packets from all four requesters
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) src_q[i].push_back({1'b1, 8'(16 * i + k)});
        end
        drive();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                exp_tag(i);
                exp_q.push_back(8'(16 * i + k));
            end
        end
        run_idle("fair", 500);
        chk_sb("fair");

        // requester 3 stalls mid-packet while requester 0 waits
        for (int k = 1; k <= 4; k++) src_q[3].push_back({(k == 4), 8'(8'h30 + k)});
        drive();
        wait_src("stall", 3, 2, 100);
        stall[3] = 1'b1;
        src_q[0].push_back(9'h101);
        drive();
        repeat (10) cycle();
        gap_valid = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (tx_valid !== 1'b0) gap_valid++;
        end
        chk("stall_tx_idle", gap_valid, 0);
        chk("stall_grant", grant_id, 3);
        chk("stall_busy", busy, 1);
        chk("stall_req0_held", src_q[0].size(), 1);
        exp_tag(3); exp_q.push_back(8'h31); exp_q.push_back(8'h32);
        chk_sb("stall_pre");
        stall[3] = 1'b0;
        drive();
        exp_q.push_back(8'h33); exp_q.push_back(8'h34);
        exp_tag(0); exp_q.push_back(8'h01);
        run_idle("stall", 300);
        chk_sb("stall_post");

        // backpressure: uart_tx not ready for 100 cycles
        ready_hold = 1'b1;
        tx_ready   = 1'b0;
        for (int k = 1; k <= 4; k++) src_q[1].push_back({(k == 4), 8'(8'h50 + k)});
        drive();
        unstable = 0;
        repeat (5) cycle();
        for (int c = 0; c < 100; c++) begin
            cycle();
            if (tx_valid !== 1'b1 || tx_data !== (TAG_ON ? 8'hA1 : 8'h51)) unstable++;
        end
        chk("bp_stable", unstable, 0);
        chk("bp_tx_data", tx_data, TAG_ON ? 8'hA1 : 8'h51);
        chk("bp_req_ready", req_ready, 4'h0);
        chk("bp_src_left", src_q[1].size(), TAG_ON ? 4 : 3);
        chk("bp_no_xfer", got_q.size(), 0);
        ready_hold = 1'b0;
        exp_tag(1);
        for (int k = 1; k <= 4; k++) exp_q.push_back(8'(8'h50 + k));
        run_idle("bp", 300);
        chk_sb("bp");

        // reset mid-packet after the 2nd of 4 bytes
        for (int k = 1; k <= 4; k++) src_q[2].push_back({(k == 4), 8'(8'hB0 + k)});
        drive();
        wait_src("mrst", 2, 2, 100);
        src_q[3].push_back(9'h1D1);
        src_q[1].push_back(9'h1E1);
        drive();
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_tx_valid", tx_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_req_ready", req_ready, 4'h0);
        src_q[2].delete();
        drive();
        cycle();
        cycle();
        got_q.delete();
        exp_q.delete();
        chk("mrst_grant_rst", grant_id, 0);
        rst = 1'b0;
        cycle();
        chk("mrst_regrant", grant_id, 1);
        exp_tag(1); exp_q.push_back(8'hE1);
        exp_tag(3); exp_q.push_back(8'hD1);
        run_idle("mrst", 300);
        chk_sb("mrst");

        chk("one_accept_per_cycle", multi_acc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
